// File: rtl/axi_fsm_pkg.sv
// Shared definitions for the AXI read/write protocol FSMs: handshake state
// encoding, burst/response codes and the captured AR control payload.
package axi_fsm_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  // Handshake phase: WAIT = idle, COMMIT = valid&&ready this cycle, ASSERT = valid held.
  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_COMMIT = 2'b01,
    ST_ASSERT = 2'b10
  } fsm_state_t;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_ctl_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_read_protocol_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus the illegal-burst flag.
// Illegal bursts that move at all advance as INCR.
module axi_burst_addr
  import axi_fsm_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]      addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [AW-1:0]      next_addr,
  output logic               illegal
);

  logic [AW-1:0] incr;
  logic [AW-1:0] container;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] incr_addr;

  always_comb begin
    incr      = AW'(1) << size;
    container = (AW'(len) + AW'(1)) << size;
    wrap_mask = container - AW'(1);
    incr_addr = addr + incr;
    illegal   = (burst == BURST_RSVD) || (size > 3'd3) ||
                ((burst == BURST_WRAP) && !wrap_len_ok(len));
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (!illegal) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_protocol.sv
// AR/R channel protocol FSMs for one AXI4 read slave port: accepts a burst,
// walks the beat addresses for the data source and returns registered R beats.
module axi_read_protocol
  import axi_fsm_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic [AW-1:0]       araddr_in,
  input  logic [LEN_W-1:0]    arlen_in,
  input  logic [SIZE_W-1:0]   arsize_in,
  input  logic [BURST_W-1:0]  arburst_in,
  input  logic                arvalid_in,
  input  logic                rready_in,
  input  logic [DW-1:0]       rdata_in,
  input  logic [RESP_W-1:0]   rresp_in,
  input  logic                rvalid_in,
  output logic [AW-1:0]       axi_araddr,
  output logic [LEN_W-1:0]    axi_arlen,
  output logic [SIZE_W-1:0]   axi_arsize,
  output logic [BURST_W-1:0]  axi_arburst,
  output logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DW-1:0]       axi_rdata,
  output logic [RESP_W-1:0]   axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  output logic                axi_rready,
  output logic [AW-1:0]       rd_addr,
  output logic                r_active
);

  fsm_state_t ar_state, ar_state_nxt;
  fsm_state_t r_state, r_state_nxt;

  ar_ctl_t       ar_ctl, ar_ctl_nxt;
  logic [AW-1:0] araddr_nxt;
  logic          arvalid_nxt, arready_nxt;
  logic          ar_commit_c;

  ar_ctl_t          b_ctl, b_ctl_nxt;
  logic [LEN_W-1:0] beats_left, beats_left_nxt;
  logic [AW-1:0]    rd_addr_nxt;
  logic             r_active_nxt;
  logic [DW-1:0]    rdata_nxt;
  logic [RESP_W-1:0] rresp_nxt;
  logic             rlast_nxt, rvalid_nxt;

  logic [AW-1:0] next_addr_c;
  logic          burst_err_c;

  assign axi_arlen   = ar_ctl.len;
  assign axi_arsize  = ar_ctl.size;
  assign axi_arburst = ar_ctl.burst;

  axi_burst_addr #(.AW(AW)) u_burst_addr (
    .addr      (rd_addr),
    .len       (b_ctl.len),
    .size      (b_ctl.size),
    .burst     (b_ctl.burst),
    .next_addr (next_addr_c),
    .illegal   (burst_err_c)
  );

  // State and registered outputs
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      ar_state    <= ST_WAIT;
      r_state     <= ST_WAIT;
      axi_araddr  <= '0;
      ar_ctl      <= '0;
      axi_arvalid <= 1'b0;
      axi_arready <= 1'b0;
      b_ctl       <= '0;
      beats_left  <= '0;
      rd_addr     <= '0;
      r_active    <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= '0;
      axi_rlast   <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      ar_state    <= ar_state_nxt;
      r_state     <= r_state_nxt;
      axi_araddr  <= araddr_nxt;
      ar_ctl      <= ar_ctl_nxt;
      axi_arvalid <= arvalid_nxt;
      axi_arready <= arready_nxt;
      b_ctl       <= b_ctl_nxt;
      beats_left  <= beats_left_nxt;
      rd_addr     <= rd_addr_nxt;
      r_active    <= r_active_nxt;
      axi_rdata   <= rdata_nxt;
      axi_rresp   <= rresp_nxt;
      axi_rlast   <= rlast_nxt;
      axi_rvalid  <= rvalid_nxt;
      axi_rready  <= rready_in;
    end
  end

  // AR next state: only one burst in flight, so a new request waits for !r_active
  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      ST_WAIT:   if (arvalid_in) ar_state_nxt = r_active ? ST_ASSERT : ST_COMMIT;
      ST_ASSERT: if (!r_active) ar_state_nxt = ST_COMMIT;
      ST_COMMIT: ar_state_nxt = arvalid_in ? ST_ASSERT : ST_WAIT;
      default:   ar_state_nxt = ST_WAIT;
    endcase
  end

  // AR outputs
  always_comb begin
    araddr_nxt  = axi_araddr;
    ar_ctl_nxt  = ar_ctl;
    arvalid_nxt = axi_arvalid;
    arready_nxt = axi_arready;
    ar_commit_c = 1'b0;
    case (ar_state)
      ST_WAIT: begin
        if (arvalid_in) begin
          araddr_nxt  = araddr_in;
          ar_ctl_nxt  = '{len: arlen_in, size: arsize_in, burst: arburst_in};
          arvalid_nxt = 1'b1;
          arready_nxt = !r_active;
        end
      end
      ST_ASSERT: begin
        if (!r_active) arready_nxt = 1'b1;
      end
      ST_COMMIT: begin
        ar_commit_c = 1'b1;
        arready_nxt = 1'b0;
        if (arvalid_in) begin
          araddr_nxt  = araddr_in;
          ar_ctl_nxt  = '{len: arlen_in, size: arsize_in, burst: arburst_in};
          arvalid_nxt = 1'b1;
        end else begin
          arvalid_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // R next state: r_state==COMMIT exactly when axi_rvalid && axi_rready
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      ST_WAIT: begin
        if (r_active && rvalid_in) r_state_nxt = rready_in ? ST_COMMIT : ST_ASSERT;
      end
      ST_ASSERT: begin
        if (rready_in) r_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (axi_rlast || !rvalid_in) r_state_nxt = ST_WAIT;
        else                         r_state_nxt = rready_in ? ST_COMMIT : ST_ASSERT;
      end
      default: r_state_nxt = ST_WAIT;
    endcase
  end

  // R outputs and burst bookkeeping
  always_comb begin
    b_ctl_nxt      = b_ctl;
    beats_left_nxt = beats_left;
    rd_addr_nxt    = rd_addr;
    r_active_nxt   = r_active;
    rdata_nxt      = axi_rdata;
    rresp_nxt      = axi_rresp;
    rlast_nxt      = axi_rlast;
    rvalid_nxt     = axi_rvalid;
    if (ar_commit_c) begin
      rd_addr_nxt    = axi_araddr;
      beats_left_nxt = ar_ctl.len;
      b_ctl_nxt      = ar_ctl;
      r_active_nxt   = 1'b1;
    end
    case (r_state)
      ST_WAIT: begin
        if (r_active && rvalid_in) begin
          rdata_nxt  = rdata_in;
          rresp_nxt  = burst_err_c ? RESP_SLVERR : rresp_in;
          rlast_nxt  = (beats_left == 8'd0);
          rvalid_nxt = 1'b1;
        end
      end
      ST_COMMIT: begin
        beats_left_nxt = beats_left - 8'd1;
        rd_addr_nxt    = next_addr_c;
        if (axi_rlast) begin
          r_active_nxt = 1'b0;
          rvalid_nxt   = 1'b0;
        end else if (rvalid_in) begin
          // beats_left is being decremented this cycle, so the new beat is last at 1
          rdata_nxt  = rdata_in;
          rresp_nxt  = burst_err_c ? RESP_SLVERR : rresp_in;
          rlast_nxt  = (beats_left == 8'd1);
          rvalid_nxt = 1'b1;
        end else begin
          rvalid_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
